// File: rtl/pll_reset_sequencer.sv
// Supervises the system PLL: pulses its reset, waits for a qualified lock with
// retry/timeout, holds the core in reset, and re-sequences on loss of lock.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int LOCK_STABLE    = 1024,
    parameter int HOLD_CYCLES    = 64,
    parameter int RETRY_MAX      = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       clear,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       lock_lost,
    output logic       fail,
    output logic [3:0] retry_count
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD = (LOCK_STABLE > HOLD_CYCLES) ? LOCK_STABLE : HOLD_CYCLES;
    localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIM   = 4'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_HOLD,
        S_RUN,
        S_FAIL
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [1:0]    sync_q, sync_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          ready_q, ready_d;
    logic          lock_lost_q, lock_lost_d;
    logic          fail_q, fail_d;
    logic          locked_s;

    assign locked_s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], pll_locked};
        state_d     = state_q;
        retry_d     = retry_q;
        lock_lost_d = clear ? 1'b0 : lock_lost_q;

        unique case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins over a retry.
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TMO_LAST) begin
                    if (retry_q == RETRY_LIM) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_RESET_PLL;
                        retry_d = retry_q + 4'd1;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s)                state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!locked_s)              state_d = S_WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d     = S_RESET_PLL;
                    retry_d     = 4'd0;
                    lock_lost_d = 1'b1;
                end
            end
            S_FAIL: begin
                if (clear) begin
                    state_d = S_RESET_PLL;
                    retry_d = 4'd0;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
                retry_d = 4'd0;
            end
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

        // Outputs are decoded from the next state so they change on the same
        // edge as the state register and leave straight from flops.
        pll_rst_d   = (state_d == S_RESET_PLL);
        sys_rst_n_d = (state_d == S_RUN);
        ready_d     = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync_q      <= sync_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign lock_lost   = lock_lost_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed timing scenarios pinned to literal
// edge numbers, then random lock/clear/reset traffic against a phase model.
module tb_pll_reset_sequencer;

    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int LOCK_STABLE    = 8;
    localparam int HOLD_CYCLES    = 4;
    localparam int RETRY_MAX      = 2;

    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_HOLD = 3, P_RUN = 4, P_FAIL = 5;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       clear;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       lock_lost;
    logic       fail;
    logic [3:0] retry_count;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .LOCK_STABLE   (LOCK_STABLE),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .RETRY_MAX     (RETRY_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .clear      (clear),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .fail       (fail),
        .retry_count(retry_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Phase model: which phase we are in, how many edges spent in it, retries
    // used, sticky loss flag, and the last two lock samples (lock is seen
    // internally two edges after it is sampled).
    int       m_ph   = P_RST;
    int       m_el   = 0;
    int       m_ret  = 0;
    bit       m_lost = 1'b0;
    bit [1:0] m_hist = 2'b00;
    int       ecnt   = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int nph, nret;
        bit nlost, ls;
        if (!rst_n) begin
            m_ph   <= P_RST;
            m_el   <= 0;
            m_ret  <= 0;
            m_lost <= 1'b0;
            m_hist <= 2'b00;
            ecnt   <= 0;
        end else begin
            ls    = m_hist[1];
            nph   = m_ph;
            nret  = m_ret;
            nlost = clear ? 1'b0 : m_lost;
            case (m_ph)
                P_RST:  if (m_el + 1 == PLL_RST_CYCLES) nph = P_WAIT;
                P_WAIT: begin
                    if (ls) nph = P_STAB;
                    else if (m_el + 1 == LOCK_TIMEOUT) begin
                        if (m_ret == RETRY_MAX) nph = P_FAIL;
                        else begin nph = P_RST; nret = m_ret + 1; end
                    end
                end
                P_STAB: if (!ls) nph = P_WAIT; else if (m_el + 1 == LOCK_STABLE) nph = P_HOLD;
                P_HOLD: if (!ls) nph = P_WAIT; else if (m_el + 1 == HOLD_CYCLES) nph = P_RUN;
                P_RUN:  if (!ls) begin nph = P_RST; nret = 0; nlost = 1'b1; end
                P_FAIL: if (clear) begin nph = P_RST; nret = 0; end
                default: nph = P_RST;
            endcase
            m_el   <= (nph != m_ph) ? 0 : m_el + 1;
            m_ph   <= nph;
            m_ret  <= nret;
            m_lost <= nlost;
            m_hist <= {m_hist[0], pll_locked};
            ecnt   <= ecnt + 1;
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp_v;
        exp_v = {m_ph == P_RST, m_ph == P_RUN, m_ph == P_RUN, m_lost, m_ph == P_FAIL, 4'(m_ret)};
        chk("outputs_vs_model", {23'd0, pll_rst, sys_rst_n, ready, lock_lost, fail, retry_count},
            {23'd0, exp_v});
    end

    task automatic to_edge(input int n);
        int guard = 0;
        while (ecnt < n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ecnt < n) chk("edge_wait_timeout", ecnt, n);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {pll_rst, sys_rst_n, ready, lock_lost, fail, retry_count}, 9'b1_0000_0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_phase(input int p, input int limit);
        int k = 0;
        while (m_ph != p && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (m_ph != p) chk("phase_wait_timeout", m_ph, p);
    endtask

    int seg;
    bit lvl;

    initial begin
        rst_n      = 1'b1;
        clear      = 1'b0;
        pll_locked = 1'b0;
        #1 rst_n   = 1'b0;

        // Clean bring-up with lock present from reset.
        pll_locked = 1'b1;
        do_reset();
        to_edge(3);  chk("clean_pll_rst_e3", pll_rst, 1);
        to_edge(4);  chk("clean_pll_rst_e4", pll_rst, 0);
        to_edge(5);  chk("clean_model_stable_e5", m_ph, P_STAB);
        to_edge(13); chk("clean_model_hold_e13", m_ph, P_HOLD);
        to_edge(16); chk("clean_sys_rst_n_e16", sys_rst_n, 0);
        to_edge(17); chk("clean_run_e17", {sys_rst_n, ready}, 2'b11);

        // Lock never arrives: two retries then FAIL, cleared back to RESET_PLL.
        pll_locked = 1'b0;
        do_reset();
        to_edge(36);  chk("nolock_retry1_e36", {pll_rst, retry_count}, 5'b1_0001);
        to_edge(40);  chk("nolock_pll_rst_e40", pll_rst, 0);
        to_edge(72);  chk("nolock_retry2_e72", {pll_rst, retry_count}, 5'b1_0010);
        to_edge(107); chk("nolock_fail_e107", fail, 0);
        to_edge(108); chk("nolock_fail_e108", fail, 1);
        to_edge(120); chk("nolock_fail_e120", fail, 1);
        clear = 1'b1;
        to_edge(121); chk("nolock_clear_e121", {fail, pll_rst, retry_count}, 6'b01_0000);
        clear = 1'b0;

        // Glitch during STABLE, then loss in RUN, then clear-vs-set.
        pll_locked = 1'b1;
        do_reset();
        to_edge(9);  pll_locked = 1'b0;
        to_edge(10); pll_locked = 1'b1;
        to_edge(12); chk("glitch_model_wait_e12", m_ph, P_WAIT);
        to_edge(13); chk("glitch_no_hold_e13", {m_ph, 31'(sys_rst_n)}, {P_STAB, 31'd0});
        to_edge(24); chk("glitch_sys_rst_n_e24", sys_rst_n, 0);
        to_edge(25); chk("glitch_run_e25", {sys_rst_n, ready}, 2'b11);
        to_edge(30); pll_locked = 1'b0;
        to_edge(32); chk("loss_still_run_e32", sys_rst_n, 1);
        to_edge(33); pll_locked = 1'b1;
        chk("loss_reset_e33", {sys_rst_n, ready, lock_lost, pll_rst}, 4'b0011);
        to_edge(36); chk("loss_pll_rst_e36", pll_rst, 1);
        to_edge(37); chk("loss_pll_rst_e37", pll_rst, 0);
        to_edge(49); chk("loss_ready_e49", ready, 0);
        to_edge(50); chk("loss_ready_e50", ready, 1);
        to_edge(55); pll_locked = 1'b0;
        to_edge(56); pll_locked = 1'b1;
        to_edge(57); clear = 1'b1;
        to_edge(58); clear = 1'b0;
        chk("clear_vs_set_e58", {lock_lost, sys_rst_n}, 2'b10);
        to_edge(60); clear = 1'b1;
        to_edge(61); clear = 1'b0;
        chk("clear_alone_e61", lock_lost, 0);
        to_edge(70); chk("lost_stays_clear_e70", lock_lost, 0);

        // Async reset asserted during HOLD takes effect before the next edge.
        to_edge(62);
        to_edge(66);
        wait_phase(P_HOLD, 100);
        to_edge(ecnt);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_hold", {pll_rst, sys_rst_n, ready, lock_lost, fail, retry_count}, 9'b1_0000_0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        to_edge(3); chk("restart_pll_rst_e3", pll_rst, 1);
        to_edge(4); chk("restart_pll_rst_e4", pll_rst, 0);

        // Random lock segments, sparse clear pulses and occasional resets.
        seg = 0;
        for (int i = 0; i < 5000; i++) begin
            if (seg == 0) begin
                lvl        = ($urandom_range(0, 3) != 0);
                pll_locked = lvl;
                if (lvl) seg = $urandom_range(1, 120);
                else if ($urandom_range(0, 4) == 0) seg = $urandom_range(90, 160);
                else seg = $urandom_range(1, 12);
            end
            seg--;
            clear = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 1499) != 0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        clear = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Supervises the system PLL and generates the design's clean core reset.
- Runs on the free-running board reference clock.
- Drives the PLL's active-high reset and watches its asynchronous lock output.
- Retries PLL bring-up on lock timeout.
- Releases sys_rst_n only after lock has been stable and a hold period has elapsed.
- Re-sequences automatically on loss of lock.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 65536, cycles to wait for lock before retrying (>=1)
LOCK_STABLE, 1024, consecutive synced-lock cycles required before HOLD (>=1)
HOLD_CYCLES, 64, cycles sys_rst_n stays low after lock is declared stable (>=1)
RETRY_MAX, 7, retries allowed before entering FAIL (0..15)

Ports:
clk  input  1  free-running reference clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
pll_locked  input  1  PLL lock, asynchronous to clk
clear  input  1  synchronous pulse; clears sticky flags, exits FAIL
pll_rst  output  1  active-high PLL reset
sys_rst_n  output  1  active-low core reset to the downstream logic
ready  output  1  high only in RUN
lock_lost  output  1  sticky; lock dropped while in RUN
fail  output  1  high in FAIL
retry_count  output  4  retries used in the current bring-up

Behaviour:
- Clocking and reset: one clock domain (clk); reset is asynchronous and active-low (rst_n).
- Lock synchronizer: pll_locked passes through a 2-FF synchronizer to give locked_s, 2-cycle latency. Only locked_s is used internally.
- Counter: a single shared counter, width $clog2 of the largest of the cycle parameters. It is cleared on every state change.
- Outputs: all outputs are registered and updated on the same edge as the state register.
- Reset values (rst_n low):
  - state RESET_PLL, cnt 0, retry_count 0
  - pll_rst 1, sys_rst_n 0, ready 0, lock_lost 0, fail 0
  - synchronizer flops 0
- States and transitions (edges counted after rst_n release):
  - RESET_PLL: pll_rst=1, sys_rst_n=0. When cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0, sys_rst_n=0.
    - If locked_s=1, go to STABLE.
    - Else if cnt==LOCK_TIMEOUT-1 and retry_count==RETRY_MAX, go to FAIL.
    - Else if cnt==LOCK_TIMEOUT-1, increment retry_count and go to RESET_PLL.
    - locked_s=1 takes priority over a timeout on the same cycle.
  - STABLE: sys_rst_n=0.
    - If locked_s=0, go to WAIT_LOCK; the timeout window restarts.
    - Else if cnt==LOCK_STABLE-1, go to HOLD.
  - HOLD: sys_rst_n=0.
    - If locked_s=0, go to WAIT_LOCK.
    - Else if cnt==HOLD_CYCLES-1, go to RUN.
  - RUN: sys_rst_n=1, ready=1.
    - If locked_s=0: on the next edge sys_rst_n=0, ready=0, lock_lost=1, retry_count=0, go to RESET_PLL.
  - FAIL: pll_rst=0, sys_rst_n=0, fail=1.
    - Stays in FAIL until clear=1.
    - On clear: go to RESET_PLL with retry_count=0, fail=0.
- clear:
  - In any state, clear=1 zeroes lock_lost.
  - If clear and a RUN lock-loss occur on the same edge, the set wins: lock_lost=1.
  - clear has no effect on state except in FAIL.
- Reset mid-operation: asserting rst_n in any state returns all registers to their reset values immediately, without waiting for an edge.
- pll_rst and sys_rst_n must never glitch; both are flop outputs with no combinational path.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, HOLD_CYCLES=4, RETRY_MAX=2.
- Clean bring-up, pll_locked=1 from reset: pll_rst falls at edge 4; STABLE at edge 5; HOLD at edge 13; sys_rst_n=1 and ready=1 at edge 17.
- No lock ever, pll_locked=0: pll_rst pulses at edges 1-4, 37-40 and 73-76; retry_count reaches 1 then 2; fail=1 at edge 108, then constant. A clear pulse restarts RESET_PLL with retry_count=0.
- Glitchy lock: pll_locked high for 5 cycles during STABLE, then low for 1 cycle. Required: return to WAIT_LOCK, no HOLD entry, sys_rst_n stays 0; full re-qualification of 8 cycles then 4 cycles.
- Loss in RUN: drop pll_locked for 3 cycles. Required: sys_rst_n=0 exactly 3 edges after the drop (2 sync + 1), lock_lost=1, pll_rst=1 for 4 cycles, ready returns after the full sequence.
- Clear vs set: pulse clear on the same edge that lock loss is registered in RUN -> lock_lost=1. A later clear pulse alone -> lock_lost=0.
- Async reset asserted during HOLD: all outputs return to reset values before the next clk edge; the sequence restarts at RESET_PLL.
